axis_packet_gen: RTL and testbench

// - AXI-Stream traffic source for cable test; feeds the rate limiter directly.
// - On START it emits framed packets of PACKET_CYCLES beats with a deterministic,

---
 rtl/axis_packet_gen_pkg.sv | 11 +
 rtl/axis_packet_gen_if.sv | 21 ++
 rtl/axis_packet_gen.sv | 120 ++++++++++++
 tb/tb_axis_packet_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/axis_packet_gen_pkg.sv
// Shared types for the AXI-Stream packet generator.
// State encodings and lane geometry.
package axis_packet_gen_pkg;
   localparam int LANE_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_FINISH
   } state_e;
endpackage

// File: rtl/axis_packet_gen_if.sv
// AXI-Stream bundle carried between the generator and its sink.
// The master drives data/framing, the slave drives TREADY.
interface axis_packet_gen_if #(
   parameter int DW = 512
);
   logic [DW-1:0]   TDATA;
   logic [DW/8-1:0] TKEEP;
   logic            TLAST;
   logic            TVALID;
   logic            TREADY;

   modport master (
      output TDATA, TKEEP, TLAST, TVALID,
      input  TREADY
   );

   modport slave (
      input  TDATA, TKEEP, TLAST, TVALID,
      output TREADY
   );
endinterface

// File: rtl/axis_packet_gen.sv
// Framed AXI-Stream traffic source; every 64-bit lane carries
// a global beat sequence number for drop/dup/reorder checks.
module axis_packet_gen
   import axis_packet_gen_pkg::*;
#(
   parameter int DW = 512
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        START,
   input  logic        STOP,
   input  logic [15:0] PACKET_CYCLES,
   input  logic [31:0] PACKET_COUNT,
   axis_packet_gen_if.master AXIS_OUT,
   output logic        BUSY,
   output logic [31:0] PACKETS_SENT
);

   state_e      state_q, state_d;
   logic [63:0] seq_q, seq_d;
   logic [15:0] beat_q, beat_d;
   logic [15:0] cyc_q, cyc_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] sent_q, sent_d;
   logic        stop_q, stop_d;
   logic        tvalid_q, tvalid_d;
   logic        tlast_q, tlast_d;
   logic        hs;
   logic        last_pkt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         seq_q    <= '0;
         beat_q   <= '0;
         cyc_q    <= 16'd1;
         cnt_q    <= '0;
         sent_q   <= '0;
         stop_q   <= 1'b0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         seq_q    <= seq_d;
         beat_q   <= beat_d;
         cyc_q    <= cyc_d;
         cnt_q    <= cnt_d;
         sent_q   <= sent_d;
         stop_q   <= stop_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      seq_d    = seq_q;
      beat_d   = beat_q;
      cyc_d    = cyc_q;
      cnt_d    = cnt_q;
      sent_d   = sent_q;
      stop_d   = stop_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      hs       = tvalid_q & AXIS_OUT.TREADY;
      // A STOP arriving with the final beat still ends the run here.
      last_pkt = stop_q | STOP |
                 ((cnt_q != 32'd0) && (sent_q + 32'd1 == cnt_q));

      unique case (state_q)
         ST_IDLE: begin
            if (START) begin
               cyc_d    = (PACKET_CYCLES == 16'd0) ? 16'd1 : PACKET_CYCLES;
               cnt_d    = PACKET_COUNT;
               seq_d    = '0;
               beat_d   = '0;
               sent_d   = '0;
               stop_d   = 1'b0;
               tvalid_d = 1'b1;
               tlast_d  = (cyc_d == 16'd1);
               state_d  = ST_SEND;
            end
         end
         ST_SEND, ST_FINISH: begin
            if (state_q == ST_SEND && STOP) begin
               stop_d  = 1'b1;
               state_d = ST_FINISH;
            end
            if (hs) begin
               seq_d = seq_q + 64'd1;
               if (tlast_q) begin
                  beat_d  = '0;
                  sent_d  = sent_q + 32'd1;
                  tlast_d = (cyc_q == 16'd1);
                  if (last_pkt) begin
                     state_d  = ST_IDLE;
                     tvalid_d = 1'b0;
                     tlast_d  = 1'b0;
                  end
               end else begin
                  beat_d  = beat_q + 16'd1;
                  tlast_d = (beat_q + 16'd2 == cyc_q);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   for (genvar k = 0; k < DW / LANE_W; k++) begin : g_lane
      assign AXIS_OUT.TDATA[k*LANE_W +: LANE_W] = seq_q;
   end

   assign AXIS_OUT.TKEEP  = '1;
   assign AXIS_OUT.TLAST  = tlast_q;
   assign AXIS_OUT.TVALID = tvalid_q;
   assign BUSY            = (state_q != ST_IDLE);
   assign PACKETS_SENT    = sent_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Directed bench for the packet generator: framing, stalls,
// stop/limit termination, reset mid-run and ignored controls.
module tb_axis_packet_gen;
   localparam int DW = 512;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        stop;
   logic [15:0] pkt_cycles;
   logic [31:0] pkt_count;
   logic        busy;
   logic [31:0] sent;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   axis_packet_gen_if #(.DW(DW)) axis ();

   axis_packet_gen #(.DW(DW)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .START         (start),
      .STOP          (stop),
      .PACKET_CYCLES (pkt_cycles),
      .PACKET_COUNT  (pkt_count),
      .AXIS_OUT      (axis),
      .BUSY          (busy),
      .PACKETS_SENT  (sent)
   );

   function automatic logic [DW-1:0] rep(input logic [63:0] s);
      logic [DW-1:0] r;
      for (int k = 0; k < DW / 64; k++) r[k*64 +: 64] = s;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, axis.TVALID, 0);
      chk({tag, "_last"}, axis.TLAST, 0);
      chk({tag, "_data"}, axis.TDATA, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_sent"}, sent, 0);
   endtask

   task automatic kick(input logic [15:0] c, input logic [31:0] n,
                       input logic with_stop);
      pkt_cycles = c;
      pkt_count  = n;
      start      = 1'b1;
      stop       = with_stop;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("first_valid", axis.TVALID, 1);
      chk("first_busy", busy, 1);
   endtask

   // Consume nb beats, expecting seq from 0 and TLAST every cyc beats.
   task automatic collect(input int nb, input int cyc, input bit rnd,
                          input int stop_at);
      int          got   = 0;
      int          beat  = 0;
      logic [63:0] es    = '0;
      bit          pv    = 0;
      bit          stopf = 0;
      logic [DW-1:0] pd;
      logic          pl;
      for (int c = 0; c < 2000 && got < nb; c++) begin
         stop        = stopf;
         stopf       = 0;
         axis.TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         chk("valid_run", axis.TVALID, 1);
         if (pv) begin
            chk("hold_data", axis.TDATA, pd);
            chk("hold_last", axis.TLAST, pl);
         end
         pv = 0;
         if (axis.TVALID && axis.TREADY) begin
            chk("data", axis.TDATA, rep(es));
            chk("last", axis.TLAST, (beat == cyc - 1));
            if (stop_at >= 0 && es == 64'(stop_at)) stopf = 1;
            es   = es + 64'd1;
            beat = (beat == cyc - 1) ? 0 : beat + 1;
            got++;
         end else if (axis.TVALID) begin
            pv = 1;
            pd = axis.TDATA;
            pl = axis.TLAST;
         end
         step();
      end
      stop = 1'b0;
      chk("beat_total", got, nb);
      chk("valid_end", axis.TVALID, 0);
      chk("busy_end", busy, 0);
   endtask

   initial begin
      resetn      = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
      pkt_cycles  = 16'd4;
      pkt_count   = 32'd3;
      axis.TREADY = 1'b0;
      step();
      step();
      chk_reset("rst");
      chk("rst_keep", axis.TKEEP, {(DW/8){1'b1}});
      resetn = 1'b1;
      step();
      chk_reset("idle");

      // 4x3 run; a stalled START with new config must not disturb it
      kick(16'd4, 32'd3, 1'b0);
      axis.TREADY = 1'b0;
      pkt_cycles  = 16'd7;
      pkt_count   = 32'd1;
      start       = 1'b1;
      step();
      start = 1'b0;
      chk("stall_data", axis.TDATA, rep(64'd0));
      collect(12, 4, 0, -1);
      chk("sent_4x3", sent, 3);

      // STOP while idle does nothing
      stop = 1'b1;
      step();
      stop = 1'b0;
      step();
      chk("idle_stop_busy", busy, 0);
      chk("idle_stop_sent", sent, 3);
      chk("idle_stop_valid", axis.TVALID, 0);

      // START+STOP together, then random backpressure
      kick(16'd4, 32'd3, 1'b1);
      collect(12, 4, 1, -1);
      chk("sent_rand", sent, 3);

      // Unlimited run ended by STOP after seq 10
      kick(16'd8, 32'd0, 1'b0);
      collect(16, 8, 0, 10);
      chk("sent_stop", sent, 2);

      // Zero cycles treated as single-beat packets
      kick(16'd0, 32'd5, 1'b0);
      collect(5, 1, 0, -1);
      chk("sent_single", sent, 5);

      // Reset while stalled with valid data
      kick(16'd4, 32'd0, 1'b0);
      axis.TREADY = 1'b0;
      step();
      chk("pre_rst_valid", axis.TVALID, 1);
      resetn = 1'b0;
      step();
      chk_reset("midrst");
      resetn = 1'b1;
      step();
      kick(16'd2, 32'd1, 1'b0);
      collect(2, 2, 0, -1);
      chk("sent_after_rst", sent, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
